// File: rtl/adc_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : adc_arbiter
//  Purpose  : Round-robin scheduler sharing one soc/eoc-handshaked converter
//             between two four-phase req/ack clients. It selects the granted
//             client's input channel, runs the converter handshake, and
//             returns the sample together with an error flag. A watchdog
//             aborts a conversion that stalls in either handshake phase.
//
//  Parameters
//    W        data width of converter sample and returned result
//    TIMEOUT  max cycles spent in either converter-handshake state
//             (1..65535)
//
//  Ports
//    clock    in   1  system clock, all state updates on posedge
//    reset    in   1  synchronous, active-high reset
//    req0     in   1  client 0 conversion request (four-phase)
//    req1     in   1  client 1 conversion request (four-phase)
//    ack0     out  1  client 0 acknowledge; data/err valid while high
//    ack1     out  1  client 1 acknowledge; data/err valid while high
//    data     out  W  last conversion result (0 after a timeout)
//    err      out  1  1 = last conversion aborted by watchdog
//    sel      out  1  converter input mux select (0 = client 0, 1 = client 1)
//    soc      out  1  start-of-conversion to converter
//    eoc      in   1  end-of-conversion (1 = idle/done, 0 = converting)
//    x        in   W  converter output sample
//
//  Revision : 1.0  initial release
// ============================================================================
module adc_arbiter #(
    parameter int W       = 8,
    parameter int TIMEOUT = 255
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req0,
    input  logic         req1,
    output logic         ack0,
    output logic         ack1,
    output logic [W-1:0] data,
    output logic         err,
    output logic         sel,
    output logic         soc,
    input  logic         eoc,
    input  logic [W-1:0] x
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE  = 2'd0;  // waiting for a request
    localparam logic [1:0] c_ST_START = 2'd1;  // soc high, waiting for eoc=0
    localparam logic [1:0] c_ST_CONV  = 2'd2;  // converting, waiting for eoc=1
    localparam logic [1:0] c_ST_ACK   = 2'd3;  // result presented to client

    // Watchdog terminal count. The timer restarts at 0 on entry to START and
    // on entry to CONV, so each phase gets exactly TIMEOUT sampled cycles.
    localparam logic [15:0] c_TMR_LAST = 16'(TIMEOUT - 1);

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [1:0]   state_q, state_d;
    logic         gnt_q,   gnt_d;     // client currently being served
    logic         last_q,  last_d;    // client served most recently
    logic [15:0]  tmr_q,   tmr_d;     // watchdog counter
    logic         soc_q,   soc_d;
    logic         ack0_q,  ack0_d;
    logic         ack1_q,  ack1_d;
    logic [W-1:0] data_q,  data_d;
    logic         err_q,   err_d;
    logic         sel_q,   sel_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic w_any_req;     // at least one client requesting
    logic w_winner;      // arbitration result for this cycle
    logic w_req_gnt;     // request line of the granted client
    logic w_tmr_done;    // watchdog reached its last allowed cycle
    logic w_abort;       // watchdog fires in the current handshake phase

    assign w_any_req  = req0 | req1;

    // On a tie, the client that was not served last wins. With only one
    // requester this reduces to "req1 ? 1 : 0".
    assign w_winner   = (req0 & req1) ? ~last_q : req1;

    assign w_req_gnt  = gnt_q ? req1 : req0;
    assign w_tmr_done = (tmr_q == c_TMR_LAST);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        tmr_d   = tmr_q;
        soc_d   = soc_q;
        ack0_d  = ack0_q;
        ack1_d  = ack1_q;
        data_d  = data_q;
        err_d   = err_q;
        sel_d   = sel_q;
        w_abort = 1'b0;

        case (state_q)
            c_ST_IDLE: begin
                // sel only ever changes here, so the converter input is stable
                // for the whole START/CONV/ACK sequence.
                if (w_any_req) begin
                    gnt_d   = w_winner;
                    sel_d   = w_winner;
                    soc_d   = 1'b1;
                    tmr_d   = 16'd0;
                    state_d = c_ST_START;
                end
            end

            c_ST_START: begin
                if (!eoc) begin
                    // Converter has accepted the start; release soc.
                    soc_d   = 1'b0;
                    tmr_d   = 16'd0;
                    state_d = c_ST_CONV;
                end else if (w_tmr_done) begin
                    w_abort = 1'b1;
                end else begin
                    tmr_d   = tmr_q + 16'd1;
                end
            end

            c_ST_CONV: begin
                // eoc is checked before the watchdog, so a converter that
                // finishes on the very last allowed cycle still succeeds.
                if (eoc) begin
                    data_d  = x;
                    err_d   = 1'b0;
                    ack0_d  = ~gnt_q;
                    ack1_d  = gnt_q;
                    state_d = c_ST_ACK;
                end else if (w_tmr_done) begin
                    w_abort = 1'b1;
                end else begin
                    tmr_d   = tmr_q + 16'd1;
                end
            end

            c_ST_ACK: begin
                // Hold ack/data/err until the granted client withdraws its
                // request. A client that already dropped req sees a single
                // cycle of ack.
                if (!w_req_gnt) begin
                    ack0_d  = 1'b0;
                    ack1_d  = 1'b0;
                    last_d  = gnt_q;
                    state_d = c_ST_IDLE;
                end
            end

            default: begin
                state_d = c_ST_IDLE;
            end
        endcase

        // Watchdog abort, shared by START and CONV: report a zero sample with
        // the error flag set and hand the result to the granted client.
        if (w_abort) begin
            soc_d   = 1'b0;
            data_d  = '0;
            err_d   = 1'b1;
            ack0_d  = ~gnt_q;
            ack1_d  = gnt_q;
            state_d = c_ST_ACK;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // last resets to 1 so that client 0 wins the first tie after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= c_ST_IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            tmr_q   <= 16'd0;
            soc_q   <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            tmr_q   <= tmr_d;
            soc_q   <= soc_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            data_q  <= data_d;
            err_q   <= err_d;
            sel_q   <= sel_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all registered)
    // ------------------------------------------------------------------------
    assign ack0 = ack0_q;
    assign ack1 = ack1_q;
    assign data = data_q;
    assign err  = err_q;
    assign sel  = sel_q;
    assign soc  = soc_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adc_arbiter
//  Purpose  : Self-checking bench for adc_arbiter. A converter model answers
//             soc with planned or random delays and pushes the expected
//             result (client, data, err, completion cycle) into a scoreboard;
//             a monitor pops and compares whenever an ack rises.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adc_arbiter;

    localparam int TO = 4;

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic       req0_tb = 1'b0;
    logic       req1_tb = 1'b0;
    logic       eoc     = 1'b1;
    logic [7:0] x       = 8'h00;
    logic       ack0, ack1, err, sel, soc;
    logic [7:0] data;

    adc_arbiter #(.W(8), .TIMEOUT(TO)) dut (
        .clock (clock),
        .reset (reset),
        .req0  (req0_tb),
        .req1  (req1_tb),
        .ack0  (ack0),
        .ack1  (ack1),
        .data  (data),
        .err   (err),
        .sel   (sel),
        .soc   (soc),
        .eoc   (eoc),
        .x     (x)
    );

    always #5 clock = ~clock;

    typedef struct { int s; int c; logic [7:0] v; } plan_t;
    typedef struct { logic cl; logic [7:0] d; logic e; int at; } exp_t;

    plan_t plan_q[$];
    exp_t  exp_q[$];
    int    served_q[$];

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    logic model_last = 1'b1;
    logic req0_at = 1'b0;
    logic req1_at = 1'b0;

    // converter / monitor working variables
    plan_t cv_p;
    exp_t  cv_e;
    int    cv_k;
    int    cv_lat;
    logic  mon_prev = 1'b0;
    exp_t  mon_e;
    int    w_cnt;

    always @(posedge clock) begin
        cyc     <= cyc + 1;
        req0_at <= req0_tb;
        req1_at <= req1_tb;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_req(input int id, input logic v);
        if (id == 0) req0_tb = v;
        else         req1_tb = v;
    endtask

    function automatic logic ack_of(input int id);
        return (id == 0) ? ack0 : ack1;
    endfunction

    task automatic wait_ack(input int id, input logic lvl);
        int n;
        n = 0;
        while (ack_of(id) !== lvl) begin
            @(negedge clock);
            n++;
            if (n > 400) begin
                chk("ack_wait_timeout", 1, 0);
                break;
            end
        end
    endtask

    task automatic client_run(input int id, input int n, input int gap_max,
                              input int hold_lo, input int hold_hi);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gap_max)) @(negedge clock);
            set_req(id, 1'b1);
            wait_ack(id, 1'b1);
            repeat ($urandom_range(hold_lo, hold_hi)) @(negedge clock);
            set_req(id, 1'b0);
            wait_ack(id, 1'b0);
        end
    endtask

    // ------------------------------------------------------------------------
    // Converter model + reference: on soc, decide the converter's behaviour,
    // derive the expected outcome from the watchdog rules, then play it out.
    // s = sampled cycles in START until eoc=0, c = sampled cycles in CONV.
    // ------------------------------------------------------------------------
    initial begin : converter
        forever begin
            @(negedge clock);
            if (soc === 1'b1) begin
                if (plan_q.size() > 0) begin
                    cv_p = plan_q.pop_front();
                end else begin
                    cv_p.s = $urandom_range(1, TO + 1);
                    cv_p.c = $urandom_range(1, TO + 2);
                    cv_p.v = 8'($urandom);
                end
                cv_e.cl = (req0_at && req1_at) ? ~model_last : req1_at;
                model_last = cv_e.cl;
                if (cv_p.s > TO) begin
                    cv_e.e = 1'b1; cv_e.d = 8'h00; cv_lat = TO;
                end else if (cv_p.c > TO) begin
                    cv_e.e = 1'b1; cv_e.d = 8'h00; cv_lat = cv_p.s + TO;
                end else begin
                    cv_e.e = 1'b0; cv_e.d = cv_p.v; cv_lat = cv_p.s + cv_p.c;
                end
                cv_e.at = cyc + cv_lat;
                exp_q.push_back(cv_e);

                cv_k = 1;
                forever begin
                    if (cv_k == cv_p.s) begin
                        eoc = 1'b0;
                        break;
                    end
                    @(negedge clock);
                    cv_k++;
                    if (soc !== 1'b1) break;
                end
                if (cv_p.s <= TO) begin
                    @(negedge clock);
                    cv_k = 1;
                    forever begin
                        if (cv_k == cv_p.c) begin
                            x   = cv_p.v;
                            eoc = 1'b1;
                            break;
                        end
                        @(negedge clock);
                        cv_k++;
                        if (ack0 || ack1) break;
                    end
                    eoc = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Monitor: pops the scoreboard on every ack rising edge.
    // ------------------------------------------------------------------------
    initial begin : monitor
        forever begin
            @(negedge clock);
            if (ack0 || ack1) begin
                chk("ack_exclusive", 64'(ack0 & ack1), 0);
                chk("soc_low_during_ack", 64'(soc), 0);
                if (!mon_prev) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_unexpected_ack", 1, 0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("grant_client", 64'(ack1), 64'(mon_e.cl));
                        chk("sel_matches_grant", 64'(sel), 64'(mon_e.cl));
                        chk("data", 64'(data), 64'(mon_e.d));
                        chk("err", 64'(err), 64'(mon_e.e));
                        chk("ack_cycle", 64'(cyc), 64'(mon_e.at));
                        served_q.push_back(int'(ack1));
                    end
                end
            end
            mon_prev = ack0 | ack1;
        end
    end

    initial begin : global_guard
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        n_bad++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // ------------------------------------------------------------------------
    // Directed scenarios followed by random traffic
    // ------------------------------------------------------------------------
    initial begin : main
        repeat (3) @(negedge clock);
        chk("rst_soc",  64'(soc),  0);
        chk("rst_ack0", 64'(ack0), 0);
        chk("rst_ack1", 64'(ack1), 0);
        chk("rst_data", 64'(data), 0);
        chk("rst_err",  64'(err),  0);
        chk("rst_sel",  64'(sel),  0);
        reset = 1'b0;
        @(negedge clock);

        // Tie and round-robin: both held, order must alternate from client 0
        served_q.delete();
        repeat (4) plan_q.push_back('{1, 2, 8'($urandom)});
        fork
            client_run(0, 2, 0, 1, 1);
            client_run(1, 2, 0, 1, 1);
        join
        chk("tie_count", 64'(served_q.size()), 4);
        for (int i = 0; i < 4; i++)
            if (i < served_q.size()) chk("tie_order", 64'(served_q[i]), 64'(i % 2));

        // Single request with exact timing
        repeat (2) @(negedge clock);
        plan_q.push_back('{1, 2, 8'h5A});
        set_req(0, 1'b1);
        @(negedge clock);
        chk("single_soc_e0", 64'(soc), 1);
        chk("single_sel",    64'(sel), 0);
        @(negedge clock);
        chk("single_soc_e1", 64'(soc), 0);
        @(negedge clock);
        chk("single_ack_e2", 64'(ack0), 0);
        @(negedge clock);
        chk("single_ack_e3",  64'(ack0), 1);
        chk("single_data_e3", 64'(data), 64'h5A);
        chk("single_err_e3",  64'(err),  0);
        set_req(0, 1'b0);
        @(negedge clock);
        chk("single_ack_e4", 64'(ack0), 0);
        chk("single_ack1",   64'(ack1), 0);

        // Start timeout: eoc never falls
        plan_q.push_back('{10, 1, 8'h77});
        set_req(0, 1'b1);
        w_cnt = 0;
        for (int i = 0; i < 30 && ack0 !== 1'b1; i++) begin
            @(negedge clock);
            if (soc) w_cnt++;
        end
        chk("start_to_soc_cycles", 64'(w_cnt), TO);
        chk("start_to_err",  64'(err),  1);
        chk("start_to_data", 64'(data), 0);
        set_req(0, 1'b0);
        wait_ack(0, 1'b0);
        chk("start_to_err_hold", 64'(err), 1);
        plan_q.push_back('{1, 1, 8'h3C});
        client_run(0, 1, 0, 0, 0);
        chk("good_clears_err", 64'(err), 0);
        chk("good_data",       64'(data), 64'h3C);

        // Conversion timeout, then boundary success and boundary abort
        plan_q.push_back('{2, 10, 8'h99});
        client_run(0, 1, 0, 0, 0);
        chk("conv_to_err",  64'(err),  1);
        chk("conv_to_data", 64'(data), 0);
        plan_q.push_back('{1, TO, 8'hA5});
        client_run(0, 1, 0, 0, 0);
        chk("conv_edge_err",  64'(err),  0);
        chk("conv_edge_data", 64'(data), 64'hA5);
        plan_q.push_back('{1, TO + 1, 8'h5C});
        client_run(1, 1, 0, 0, 0);
        chk("conv_over_err", 64'(err), 1);

        // Early release: one-cycle request pulse
        plan_q.push_back('{1, 1, 8'hFF});
        set_req(1, 1'b1);
        @(negedge clock);
        set_req(1, 1'b0);
        w_cnt = 0;
        repeat (12) begin
            @(negedge clock);
            if (ack1) w_cnt++;
        end
        chk("early_ack_width", 64'(w_cnt), 1);
        chk("early_data",      64'(data),  64'hFF);
        chk("early_soc_idle",  64'(soc),   0);

        // Reset during CONV with req0 held
        plan_q.push_back('{1, 3, 8'h11});
        plan_q.push_back('{1, 1, 8'h33});
        set_req(0, 1'b1);
        @(negedge clock);
        @(negedge clock);
        chk("pre_reset_soc", 64'(soc), 0);
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_soc",  64'(soc),  0);
        chk("midrst_ack0", 64'(ack0), 0);
        chk("midrst_ack1", 64'(ack1), 0);
        chk("midrst_data", 64'(data), 0);
        chk("midrst_err",  64'(err),  0);
        chk("midrst_sel",  64'(sel),  0);
        repeat (3) @(negedge clock);
        exp_q.delete();
        model_last = 1'b1;
        reset = 1'b0;
        @(negedge clock);
        chk("restart_soc", 64'(soc), 1);
        wait_ack(0, 1'b1);
        chk("restart_data", 64'(data), 64'h33);
        set_req(0, 1'b0);
        wait_ack(0, 1'b0);

        // Random concurrent traffic
        fork
            client_run(0, 15, 3, 0, 2);
            client_run(1, 15, 3, 0, 2);
        join
        repeat (5) @(negedge clock);
        chk("sb_drained", 64'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
